// File: rtl/serial_pkg.sv
// Shared types and sizes for the serial capture path: lane count, frame width,
// receiver states, error flag positions and the buffered frame record.
package serial_pkg;

  localparam int NUM_CH   = 8;
  localparam int MAX_BITS = 128;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DISCARD = 2'd2
  } rx_state_e;

  localparam int ERR_MULTI = 0;
  localparam int ERR_OVF   = 1;
  localparam int ERR_DROP  = 2;

  typedef struct packed {
    logic [MAX_BITS-1:0] data;
    logic [CNT_W-1:0]    len;
    logic [NUM_CH-1:0]   ch;
    logic                ovf;
  } rx_frame_t;

endpackage

// File: rtl/rx_frame_buffer.sv
// One-entry valid/ready holding register for captured frames. A push that
// meets a full buffer with no transfer in the same cycle is rejected and flagged.
module rx_frame_buffer
  import serial_pkg::*;
(
  input  logic      clk_out16x,
  input  logic      rst_n,
  input  logic      push,
  input  rx_frame_t push_frame,
  input  logic      pop_ready,
  output logic      out_valid,
  output rx_frame_t out_frame,
  output logic      drop
);

  logic      valid_reg;
  rx_frame_t frame_reg;
  logic      load;

  // A transfer in the same cycle frees the slot, so the new frame may load.
  assign load = push && (!valid_reg || pop_ready);
  assign drop = push && valid_reg && !pop_ready;

  always_ff @(posedge clk_out16x or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      frame_reg <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      frame_reg <= push_frame;
    end else if (valid_reg && pop_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign out_frame = frame_reg;

endmodule

// File: rtl/serial_input_capture.sv
// Captures one MSB-first burst from a single one-hot-qualified lane into a
// left-aligned word and hands it, with length and channel, to a one-entry buffer.
module serial_input_capture
  import serial_pkg::*;
(
  input  logic                clk_out16x,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   ser_data,
  input  logic [NUM_CH-1:0]   ser_vld,
  input  logic                frame_ready,
  input  logic                err_clr,
  output logic                frame_valid,
  output logic [MAX_BITS-1:0] frame_data,
  output logic [CNT_W-1:0]    frame_len,
  output logic [NUM_CH-1:0]   frame_ch,
  output logic                frame_ovf,
  output logic                rx_busy,
  output logic [2:0]          err_pulse,
  output logic [2:0]          err_status
);

  rx_state_e           state_reg, state_next;
  logic [NUM_CH-1:0]   ch_reg, ch_next;
  logic [MAX_BITS-1:0] word_reg, word_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                ovf_reg, ovf_next;
  logic [2:0]          err_pulse_reg, err_pulse_next;
  logic [2:0]          err_status_reg;

  logic                push;
  logic                buf_drop;
  rx_frame_t           push_frame;
  rx_frame_t           out_frame;

  logic                vld_multi;
  logic                idle_bit;
  logic                lane_vld;
  logic                lane_bit;
  logic                other_vld;
  logic [CNT_W-1:0]    bit_idx;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign vld_multi = |(ser_vld & (ser_vld - NUM_CH'(1)));
  assign idle_bit  = |(ser_data & ser_vld);
  assign lane_vld  = |(ser_vld & ch_reg);
  assign lane_bit  = |(ser_data & ch_reg);
  assign other_vld = |(ser_vld & ~ch_reg);
  assign bit_idx   = CNT_W'(MAX_BITS - 1) - cnt_reg;

  always_comb begin
    state_next     = state_reg;
    ch_next        = ch_reg;
    word_next      = word_reg;
    cnt_next       = cnt_reg;
    ovf_next       = ovf_reg;
    err_pulse_next = '0;
    push           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ser_vld != '0) begin
          if (vld_multi) begin
            err_pulse_next[ERR_MULTI] = 1'b1;
            state_next                = DISCARD;
          end else begin
            ch_next    = ser_vld;
            word_next  = {idle_bit, {(MAX_BITS-1){1'b0}}};
            cnt_next   = CNT_W'(1);
            ovf_next   = 1'b0;
            state_next = RECV;
          end
        end
      end
      RECV: begin
        if (lane_vld) begin
          if (cnt_reg < CNT_W'(MAX_BITS)) begin
            word_next = word_reg | ({{(MAX_BITS-1){1'b0}}, lane_bit} << bit_idx);
            cnt_next  = cnt_reg + CNT_W'(1);
          end else begin
            ovf_next                = 1'b1;
            err_pulse_next[ERR_OVF] = !ovf_reg;
          end
          if (other_vld) begin
            err_pulse_next[ERR_MULTI] = 1'b1;
          end
        end else begin
          push       = 1'b1;
          state_next = IDLE;
        end
      end
      DISCARD: begin
        if (ser_vld == '0) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    err_pulse_next[ERR_DROP] = buf_drop;
  end

  always_ff @(posedge clk_out16x or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      ch_reg         <= '0;
      word_reg       <= '0;
      cnt_reg        <= '0;
      ovf_reg        <= 1'b0;
      err_pulse_reg  <= '0;
      err_status_reg <= '0;
    end else begin
      state_reg      <= state_next;
      ch_reg         <= ch_next;
      word_reg       <= word_next;
      cnt_reg        <= cnt_next;
      ovf_reg        <= ovf_next;
      err_pulse_reg  <= err_pulse_next;
      // A new pulse overrides a simultaneous clear.
      err_status_reg <= (err_clr ? 3'b000 : err_status_reg) | err_pulse_reg;
    end
  end

  assign push_frame = '{data: word_reg, len: cnt_reg, ch: ch_reg, ovf: ovf_reg};

  rx_frame_buffer u_buffer (
    .clk_out16x (clk_out16x),
    .rst_n      (rst_n),
    .push       (push),
    .push_frame (push_frame),
    .pop_ready  (frame_ready),
    .out_valid  (frame_valid),
    .out_frame  (out_frame),
    .drop       (buf_drop)
  );

  assign frame_data = out_frame.data;
  assign frame_len  = out_frame.len;
  assign frame_ch   = out_frame.ch;
  assign frame_ovf  = out_frame.ovf;
  assign rx_busy    = (state_reg == RECV);
  assign err_pulse  = err_pulse_reg;
  assign err_status = err_status_reg;

endmodule

// File: doc/serial_input_capture.md
Name: serial_input_capture

Overview:
- Receive-side counterpart of the 8-channel serial output stage.
- Monitors eight one-hot-qualified serial lanes, captures one MSB-first burst of up to 128 bits, and rebuilds the left-aligned 128-bit word.
- Presents the rebuilt word with bit length and channel ID through a one-entry valid/ready buffer.
- Used as loopback checker and as front end of the downstream CRC/decoder path.

Parameters:
- NUM_CH, 8, number of serial lanes; bit i of each lane vector = channel i+1.
- MAX_BITS, 128, capture register width and maximum frame length.
- CNT_W, 16, width of the bit counter and frame_len.

Ports:
- clk_out16x  input  1  bit clock, same domain as the transmitter.
- rst_n  input  1  reset, asynchronous, active-low.
- ser_data  input  NUM_CH  serial data per lane.
- ser_vld  input  NUM_CH  per-lane data valid.
- frame_ready  input  1  consumer accepts the frame.
- err_clr  input  1  clears err_status.
- frame_valid  output  1  buffered frame available.
- frame_data  output  MAX_BITS  first received bit at [127]; unreceived low bits are 0.
- frame_len  output  CNT_W  bits captured, 1..128.
- frame_ch  output  NUM_CH  one-hot channel of the frame.
- frame_ovf  output  1  frame exceeded MAX_BITS and was truncated.
- rx_busy  output  1  high while state == RECV.
- err_pulse  output  3  one-cycle event flags: [0] multi, [1] overflow, [2] drop.
- err_status  output  3  sticky OR of err_pulse.

Behaviour:
- Reset: all outputs 0, state IDLE, capture register and counter 0, buffer empty. Reset mid-frame discards the partial frame; no frame is delivered.
- States: IDLE, RECV, DISCARD.
- IDLE
  - ser_vld == 0: stay in IDLE.
  - ser_vld exactly one-hot: latch ch = ser_vld; clear the capture register; write ser_data[ch] to bit 127; cnt = 1; go to RECV.
  - ser_vld has more than one bit set: err_pulse[0] = 1; go to DISCARD.
- RECV (latched lane vld high)
  - If cnt < MAX_BITS: write the bit at index 127 - cnt, then cnt + 1.
  - Else: drop the bit, set ovf_pending, and pulse err_pulse[1] once per frame.
  - Any non-latched lane vld high: err_pulse[0]; that lane is ignored; the frame continues.
- RECV (latched lane vld low): end of frame.
  - Offer {word, cnt, ch, ovf_pending} to the buffer; go to IDLE.
  - Other lanes in this cycle are evaluated next cycle from IDLE.
- DISCARD: stay until ser_vld == 0, then go to IDLE. Bits are not captured.
- Latency: vld high cycles 0..N-1, low at cycle N → frame_valid = 1 at cycle N+1 (registered). Back-to-back frames with a one-cycle gap are supported.
- Buffer
  - frame_* outputs hold stable while frame_valid && !frame_ready.
  - Transfer occurs when frame_valid && frame_ready.
  - End-of-frame with buffer full and no transfer in that cycle: new frame dropped, err_pulse[2], old frame kept.
  - End-of-frame in the same cycle as a transfer: new frame loads, no drop.
- err_status: bit set on pulse, cleared by err_clr; set wins when both occur in the same cycle.
- frame_len counts only stored bits, so it saturates at MAX_BITS.

Decomposition:
- Package serial_pkg:
  - NUM_CH, MAX_BITS, CNT_W.
  - rx_state_e {IDLE, RECV, DISCARD}.
  - ERR_MULTI = 0, ERR_OVF = 1, ERR_DROP = 2.
  - rx_frame_t struct: data, len, ch, ovf.
- One sub-module: rx_frame_buffer, a one-entry valid/ready holding register for rx_frame_t with push, pop and drop-detect logic.

Test Plan:
- Single frame: ser_vld[2] high 16 cycles carrying 0xA5C3 MSB-first → frame_valid at cycle 17; frame_data = 0xA5C3 << 112; frame_len = 16; frame_ch = 8'h04; frame_ovf = 0.
- Full frame: ser_vld[7] high 128 cycles with a random word W → frame_data = W; frame_len = 128; frame_ch = 8'h80. Loopback against the transmitter with data_count = 128 gives an identical word.
- Overflow: ser_vld[0] high 130 cycles → frame_len = 128; frame_ovf = 1; exactly one err_pulse[1]; err_status[1] = 1 until err_clr.
- Multi-lane: ser_vld = 8'h03 for 5 cycles from IDLE → err_pulse[0] once; no frame. A following one-hot frame is captured correctly.
- Backpressure: frame_ready = 0 for two consecutive 8-bit frames (0x3C on ch1, then 0xF0 on ch2) → err_pulse[2]; buffer still holds 0x3C/ch1.
- Reset mid-frame: rst_n low after 40 bits → all outputs 0; no frame_valid after release.
